// File: rtl/spi_adc_reader_pkg.sv
// adc_pkg: shared FSM state type, frame constants and command-word builder for the SPI ADC reader
package adc_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS = 12;
  localparam int CH_W = 3;
  localparam int ADDR_LSB = 11;
  function automatic logic [FRAME_BITS-1:0] cmd_word(input logic [CH_W-1:0] ch);
    cmd_word = '0;
    cmd_word[ADDR_LSB +: CH_W] = ch;
  endfunction
endpackage

// File: rtl/spi_adc_reader_if.sv
// spi_adc_reader_if: SPI pin bundle between the reader (master) and the external ADC (slave)
// adc_sclk/adc_cs_n/adc_mosi driven by master, adc_miso driven by slave
interface spi_adc_reader_if;
  logic adc_sclk;
  logic adc_cs_n;
  logic adc_mosi;
  logic adc_miso;
  modport master(output adc_sclk, adc_cs_n, adc_mosi, input adc_miso);
  modport slave(input adc_sclk, adc_cs_n, adc_mosi, output adc_miso);
endinterface

// File: rtl/spi_adc_reader_tick_gen.sv
// adc_tick_gen: modulo-N counter issuing a one-cycle tick on its last count
// ports: clk, rst (sync high), clear (sync restart at 0), en (advance), tick (count == N-1)
module adc_tick_gen #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(N);
  logic [W-1:0] cnt;
  assign tick = en && !clear && cnt == W'(N - 1);
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/spi_adc_reader.sv
// spi_adc_reader: periodic 16-bit SPI frames to an 8-channel 12-bit ADC, holding the latest result
// ports: clk, reset (sync high), enable, channel -> spi (master pins), adc_value/adc_ch (held result),
//        valid (one-cycle update pulse), busy (frame in progress)
module spi_adc_reader
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int SAMPLE_PERIOD = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CH_W-1:0]      channel,
  spi_adc_reader_if.master     spi,
  output logic [DATA_BITS-1:0] adc_value,
  output logic [CH_W-1:0]      adc_ch,
  output logic                 valid,
  output logic                 busy
);
  state_t state, state_n;
  logic st_tick, h_tick, sclk_q;
  logic [3:0] k;
  logic [CH_W-1:0] cur_ch, prev_ch;
  logic [FRAME_BITS-1:0] shift, cmd;
  adc_tick_gen #(.N(SAMPLE_PERIOD)) u_timer (
    .clk(clk), .rst(reset), .clear(1'b0), .en(1'b1), .tick(st_tick)
  );
  adc_tick_gen #(.N(CLK_DIV)) u_half (
    .clk(clk), .rst(reset), .clear(state == IDLE), .en(1'b1), .tick(h_tick)
  );
  assign cmd = cmd_word(cur_ch);
  assign busy = state inside {SETUP, SHIFT, HOLD};
  assign valid = state == DONE;
  assign spi.adc_cs_n = !busy;
  assign spi.adc_sclk = state == SHIFT ? sclk_q : 1'b1;
  // k only moves on falling sclk, so mosi changes exactly at falling edges
  assign spi.adc_mosi = (state == SETUP || state == SHIFT) ? cmd[k] : 1'b0;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = st_tick && enable ? SETUP : IDLE;
      SETUP:   state_n = h_tick ? SHIFT : SETUP;
      SHIFT:   state_n = h_tick && sclk_q && k == '0 ? HOLD : SHIFT;
      HOLD:    state_n = h_tick ? DONE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      sclk_q    <= 1'b0;
      cur_ch    <= '0;
      prev_ch   <= '0;
      shift     <= '0;
      adc_value <= '0;
      adc_ch    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        k      <= 4'(FRAME_BITS - 1);
        sclk_q <= 1'b0;
        cur_ch <= channel;
      end
      if (state == SHIFT && h_tick) begin
        if (!sclk_q) begin
          sclk_q <= 1'b1;
          shift  <= FRAME_BITS'({shift, spi.adc_miso});
        end else if (k != '0) begin
          sclk_q <= 1'b0;
          k      <= k - 4'd1;
        end
      end
      // the ADC returns the conversion addressed by the previous frame
      if (state == HOLD && h_tick) begin
        adc_value <= shift[DATA_BITS-1:0];
        adc_ch    <= prev_ch;
        prev_ch   <= cur_ch;
      end
    end
  end
endmodule

// File: tb/tb_spi_adc_reader.sv
// tb_spi_adc_reader: randomized scoreboard bench with an ADC slave model for spi_adc_reader
module tb_spi_adc_reader;
  localparam int D = 2;
  localparam int P = 100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [2:0] channel = 3'd0;
  logic miso = 1'b0;
  logic [11:0] adc_value;
  logic [2:0] adc_ch;
  logic valid, busy;
  spi_adc_reader_if spi ();
  assign spi.adc_miso = miso;
  spi_adc_reader #(.CLK_DIV(D), .SAMPLE_PERIOD(P)) dut (
    .clk(clk), .reset(reset), .enable(enable), .channel(channel), .spi(spi),
    .adc_value(adc_value), .adc_ch(adc_ch), .valid(valid), .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  logic rst_h = 1'b1;
  logic en_h = 1'b0;
  logic [2:0] ch_h = 3'd0;
  int n = 0;
  always @(posedge clk) begin
    rst_h <= reset;
    en_h  <= enable;
    ch_h  <= channel;
    n     <= reset ? 0 : n + 1;
  end
  logic [14:0] exp_q[$];
  logic [15:0] word_q[$];
  logic [15:0] word = 16'd0;
  logic [15:0] cmd_rx = 16'd0;
  logic [14:0] e, prev_out = 15'd0;
  logic [2:0] model_prev = 3'd0;
  logic [2:0] frame_ch = 3'd0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;
  int low_cnt = 0, rises = 0;
  always @(negedge clk) begin
    if (rst_h) begin
      exp_q.delete();
      model_prev = 3'd0;
      prev_cs = 1'b1;
      prev_sclk = 1'b1;
      prev_valid = 1'b0;
      prev_out = 15'd0;
      rises = 0;
      low_cnt = 0;
      miso = 1'b0;
    end else begin
      check("busy_vs_cs", busy, !spi.adc_cs_n);
      if (n > 0 && n % P == 0) check("frame_start", !spi.adc_cs_n, en_h);
      if (prev_cs && !spi.adc_cs_n) begin
        check("start_align", n % P, 0);
        word = word_q.size() > 0 ? word_q.pop_front() : 16'($urandom);
        exp_q.push_back({model_prev, word[11:0]});
        model_prev = ch_h;
        frame_ch = ch_h;
        low_cnt = 0;
        rises = 0;
        cmd_rx = 16'd0;
      end
      if (!spi.adc_cs_n) begin
        low_cnt++;
        if (prev_sclk && !spi.adc_sclk && rises < 16) miso = word[15-rises];
        if (!prev_sclk && spi.adc_sclk) begin
          cmd_rx = {cmd_rx[14:0], spi.adc_mosi};
          rises++;
        end
      end
      if (!prev_cs && spi.adc_cs_n) begin
        check("cs_low_len", low_cnt, 34 * D);
        check("sclk_rises", rises, 16);
        check("cmd_word", cmd_rx, 32'(frame_ch) * 2048);
      end
      if (valid) begin
        check("valid_width", prev_valid, 0);
        check("valid_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("adc_value", adc_value, e[11:0]);
          check("adc_ch", adc_ch, e[14:12]);
        end
      end else check("hold_stable", {adc_ch, adc_value}, prev_out);
      prev_cs = spi.adc_cs_n;
      prev_sclk = spi.adc_sclk;
      prev_valid = valid;
      prev_out = {adc_ch, adc_value};
    end
  end
  task automatic cycles(input int c);
    repeat (c) @(negedge clk);
  endtask
  task automatic wait_start();
    int t = 0;
    while (spi.adc_cs_n && t < 3 * P) begin
      @(negedge clk);
      t++;
    end
    check("start_timeout", spi.adc_cs_n, 0);
  endtask
  task automatic check_reset_state();
    check("rst_cs_n", spi.adc_cs_n, 1);
    check("rst_sclk", spi.adc_sclk, 1);
    check("rst_mosi", spi.adc_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_value", adc_value, 0);
    check("rst_ch", adc_ch, 0);
  endtask
  initial begin
    int t;
    word_q.push_back(16'h0ABC);
    word_q.push_back(16'hF123);
    cycles(3);
    check_reset_state();
    reset = 1'b0;
    enable = 1'b1;
    channel = 3'd5;
    cycles(150);
    channel = 3'd2;
    cycles(130);
    enable = 1'b0;
    cycles(300);
    check("hold_value_disabled", adc_value, 12'h123);
    check("hold_ch_disabled", adc_ch, 3'd5);
    enable = 1'b1;
    wait_start();
    cycles(10);
    enable = 1'b0;
    cycles(80);
    check("late_disable_drained", exp_q.size(), 0);
    enable = 1'b1;
    wait_start();
    t = 0;
    while (!(rises == 8 && !spi.adc_sclk) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("bit7_reached", rises, 8);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      channel = 3'($urandom);
    end
    for (int i = 0; i < 10; i++) begin
      channel = 3'($urandom_range(0, 7));
      cycles(P);
    end
    enable = 1'b0;
    cycles(2 * P);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_adc_reader.md
Name: spi_adc_reader

Overview:
Producer side of the ADC value the data memory exposes to the processor at 0xC000_000C. Periodically runs a 16-bit SPI frame against an external 8-channel, 12-bit serial ADC (ADC128S022-style protocol) and holds the latest result stable on adc_value for memory-mapped reads. Sits at top level between the ADC pins and dmem's adc_value input.

Parameters:
CLK_DIV, 25, clk cycles per SCLK half-period (SCLK = clk/(2*CLK_DIV)); must be >= 2
SAMPLE_PERIOD, 50000, clk cycles between frame starts; must be >= 34*CLK_DIV+2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = periodic conversions run; 0 = no new frames start
channel  input  3  ADC channel to select in the next frame
adc_sclk  output  1  SPI clock to the ADC, idle high
adc_cs_n  output  1  ADC chip select, active low
adc_mosi  output  1  ADC DIN (command bits)
adc_miso  input  1  ADC DOUT
adc_value  output  12  latest conversion result, held between frames
adc_ch  output  3  channel that adc_value was converted from
valid  output  1  one-cycle pulse when adc_value/adc_ch update
busy  output  1  1 while a frame is in progress (cs_n low, including setup/hold)

Behaviour:
- Synchronous, active-high reset; one clock, clk. Reset values: adc_sclk=1, adc_cs_n=1, adc_mosi=0, adc_value=0, adc_ch=0, valid=0, busy=0, sample timer=0, prev_ch=0, state=IDLE.
- Sample timer: free-running 0..SAMPLE_PERIOD-1, wraps; a tick is generated when it reaches SAMPLE_PERIOD-1. It counts regardless of enable and state.
- Half-period tick: a counter 0..CLK_DIV-1, cleared when leaving IDLE; it advances the FSM only outside IDLE.
- FSM states:
  IDLE: cs_n=1, sclk=1. On a tick with enable=1, latch channel into cur_ch, go to SETUP, assert cs_n=0 and busy=1. A tick arriving outside IDLE, or with enable=0, is dropped (no queueing).
  SETUP: hold one half-period (CLK_DIV cycles), sclk=1, mosi = command bit 15; then go to SHIFT.
  SHIFT: 16 bits, k=15..0 (MSB first). Each bit is a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles. At each sclk falling transition, mosi = cmd[k]. At each sclk rising transition (low->high registered edge), shift adc_miso into a 16-bit shift register. After the 16th high phase, go to HOLD.
  HOLD: one half-period, sclk=1, cs_n=0; then cs_n=1, busy=0, go to DONE.
  DONE: one cycle. adc_value=shift[11:0], adc_ch=prev_ch, valid=1, prev_ch=cur_ch; return to IDLE.
- Command word: {2'b00, cur_ch[2:0], 11'b0}. ADD2..0 sit in bit positions 13..11 (3rd to 5th bits sent).
- Pipelining: the ADC converts the channel addressed in the previous frame, so the result is tagged with prev_ch. After reset, the first result is tagged channel 0.
- Upper 4 MISO bits (shift[15:12]) are ignored; no error flag.
- Frame length: cs_n low for exactly 34*CLK_DIV cycles; exactly 16 sclk rising edges per frame.
- adc_value/adc_ch change only in DONE; they are stable at all other times, including when enable=0.
- enable deasserted mid-frame: the frame completes normally, including the DONE update.
- channel changes mid-frame: ignored until the next frame start.
- Reset mid-frame: in the next cycle all outputs return to reset values (cs_n=1, sclk=1), the partial frame is discarded, adc_value=0, and no valid pulse is issued.

Decomposition:
- Package adc_pkg: state enum (IDLE, SETUP, SHIFT, HOLD, DONE), FRAME_BITS=16, DATA_BITS=12, CH_W=3, ADDR_LSB=11.
- One natural sub-module, adc_tick_gen: the parameterised modulo counter used twice (sample timer, half-period tick). Inputs clear/enable; output tick.

Test Plan:
- CLK_DIV=2, SAMPLE_PERIOD=100, enable=1, channel=5, slave model drives 0x0ABC -> cs_n falls in the cycle after timer reaches 99; cs_n low for 68 cycles; 16 sclk rising edges; mosi bits 3..5 sent = 1,0,1, all other bits 0; valid pulses once; adc_value=0xABC; adc_ch=0.
- Second frame, channel=2, slave drives 0xF123 -> adc_value=0x123 (upper nibble ignored); adc_ch=5; mosi address bits = 0,1,0.
- enable=0 across 3 sample periods -> cs_n stays 1, no valid pulse, adc_value holds 0x123. Deassert enable 10 cycles into a frame -> that frame completes and updates.
- Assert reset at SHIFT bit 7 -> next cycle cs_n=1, sclk=1, busy=0, adc_value=0; no valid pulse; the next frame starts SAMPLE_PERIOD cycles after reset release.
- Toggle channel every cycle during a frame -> transmitted address equals the channel value at frame start.
- Check valid is exactly 1 cycle wide; check adc_value is unchanged between valid pulses over 10 frames of random data.
